// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed hex display scanner. A prescaler paces the digit
// index; new values are double-buffered and shown only from a frame
// boundary. Optional blanking suppresses leading zero digits.
module display_scan_ctrl #(
   parameter int unsigned DIV = 50000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        blank_en,
   output logic [3:0]  hex,
   input  logic [1:7]  leds,
   output logic [1:7]  seg,
   output logic [3:0]  an,
   output logic        pending,
   output logic        frame_done
);

   localparam logic [15:0] CNT_MAX = 16'(DIV - 1);

   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  dig_q, dig_d;
   logic [15:0] disp_q, disp_d;
   logic [15:0] shd_q, shd_d;
   logic        pending_q, pending_d;
   logic [1:7]  seg_q, seg_d;
   logic [3:0]  an_q, an_d;
   logic        tick;
   logic        boundary;
   logic        blank_dig;

   // Prescaler, digit index and double-buffered display value
   always_comb begin
      tick      = (cnt_q == CNT_MAX);
      boundary  = tick && (dig_q == 2'd3);
      cnt_d     = tick ? '0 : cnt_q + 16'd1;
      dig_d     = tick ? dig_q + 2'd1 : dig_q;
      disp_d    = disp_q;
      shd_d     = shd_q;
      pending_d = pending_q;
      if (load && boundary) begin
         // Load on the boundary goes straight to the display, nothing left pending
         disp_d    = value;
         shd_d     = value;
         pending_d = 1'b0;
      end else begin
         if (boundary && pending_q) begin
            disp_d    = shd_q;
            pending_d = 1'b0;
         end
         if (load) begin
            shd_d     = value;
            pending_d = 1'b1;
         end
      end
   end

   // Leading-zero blanking and next segment/anode drive for the current digit
   always_comb begin
      blank_dig = 1'b0;
      if (blank_en) begin
         case (dig_q)
            2'd1:    blank_dig = (disp_q[15:4] == '0);
            2'd2:    blank_dig = (disp_q[15:8] == '0);
            2'd3:    blank_dig = (disp_q[15:12] == '0);
            default: blank_dig = 1'b0;
         endcase
      end
      if (blank_dig) begin
         an_d  = '1;
         seg_d = '1;
      end else begin
         an_d  = ~(4'b0001 << dig_q);
         seg_d = leds;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt_q     <= '0;
         dig_q     <= '0;
         disp_q    <= '0;
         shd_q     <= '0;
         pending_q <= 1'b0;
         seg_q     <= '1;
         an_q      <= '1;
      end else begin
         cnt_q     <= cnt_d;
         dig_q     <= dig_d;
         disp_q    <= disp_d;
         shd_q     <= shd_d;
         pending_q <= pending_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign hex        = 4'(disp_q >> {dig_q, 2'b00});
   assign seg        = seg_q;
   assign an         = an_q;
   assign pending    = pending_q;
   assign frame_done = boundary;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a cycle-level reference model
// pushes expected outputs each clock, a monitor pops and compares them.
module tb_display_scan_ctrl;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic        blank_en = 1'b0;
   logic [3:0]  hex;
   logic [1:7]  leds;
   logic [1:7]  seg;
   logic [3:0]  an;
   logic        pending;
   logic        frame_done;

   typedef struct {
      logic [3:0] an;
      logic [1:7] seg;
      logic [3:0] hex;
      logic       pending;
      logic       frame_done;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   int          t = 0;
   logic [15:0] disp_m = '0;
   logic [15:0] shd_m = '0;
   logic        pend_m = 1'b0;

   display_scan_ctrl #(.DIV(DIV)) dut (
      .Clock(Clock), .Reset(Reset), .load(load), .value(value),
      .blank_en(blank_en), .hex(hex), .leds(leds), .seg(seg), .an(an),
      .pending(pending), .frame_done(frame_done)
   );

   always #5 Clock = ~Clock;

   function automatic logic [1:7] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'b0000001;  4'h1: seg7 = 7'b1001111;
         4'h2: seg7 = 7'b0010010;  4'h3: seg7 = 7'b0000110;
         4'h4: seg7 = 7'b1001100;  4'h5: seg7 = 7'b0100100;
         4'h6: seg7 = 7'b0100000;  4'h7: seg7 = 7'b0001111;
         4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0000100;
         4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b1100000;
         4'hC: seg7 = 7'b0110001;  4'hD: seg7 = 7'b1000010;
         4'hE: seg7 = 7'b0110000;  default: seg7 = 7'b0111000;
      endcase
   endfunction

   // external shared decoder
   assign leds = seg7(hex);

   // reference model: advances one clock and queues the expected outputs
   always @(posedge Clock) begin
      exp_t e;
      int   k;
      logic bnd, blank;
      if (Reset) begin
         t = 0; disp_m = '0; shd_m = '0; pend_m = 1'b0;
         e.an = 4'hF; e.seg = 7'h7F;
      end else begin
         k     = (t / DIV) % 4;
         bnd   = (t % FRAME) == FRAME - 1;
         blank = blank_en && k > 0 && ((disp_m >> (4 * k)) == 0);
         e.an  = blank ? 4'hF : 4'(~(1 << k));
         e.seg = blank ? 7'h7F : seg7(4'((disp_m >> (4 * k)) & 16'hF));
         if (load && bnd) begin
            disp_m = value; shd_m = value; pend_m = 1'b0;
         end else begin
            if (bnd && pend_m) begin disp_m = shd_m; pend_m = 1'b0; end
            if (load) begin shd_m = value; pend_m = 1'b1; end
         end
         t = t + 1;
      end
      e.pending    = pend_m;
      e.frame_done = (t % FRAME) == FRAME - 1;
      e.hex        = 4'((disp_m >> (4 * ((t / DIV) % 4))) & 16'hF);
      exp_q.push_back(e);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // monitor: compare DUT outputs against the queued expectation mid-cycle
   always @(negedge Clock) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("an", int'(an), int'(e.an));
         chk("seg", int'(seg), int'(e.seg));
         chk("hex", int'(hex), int'(e.hex));
         chk("pending", int'(pending), int'(e.pending));
         chk("frame_done", int'(frame_done), int'(e.frame_done));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge Clock);
         #2;
      end
   endtask

   task automatic pulse(input logic [15:0] v);
      load = 1'b1; value = v;
      cyc(1);
      load = 1'b0;
   endtask

   task automatic wait_phase(input int ph);
      bit found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
         if ((t % FRAME) == ph) found = 1;
         else cyc(1);
      end
      if (!found) chk("wait_phase_timeout", 0, 1);
   endtask

   initial begin
      int r;
      logic [15:0] v;
      Reset = 1'b1;
      cyc(2);
      Reset = 1'b0;
      cyc(4);
      // mid-frame load while digit 1 is active
      wait_phase(DIV + 1);
      pulse(16'h1234);
      cyc(40);
      // leading-zero blanking on and off
      blank_en = 1'b1;
      pulse(16'h0005);
      cyc(40);
      blank_en = 1'b0;
      cyc(20);
      // load exactly on the boundary tick
      wait_phase(FRAME - 1);
      pulse(16'hABCD);
      cyc(20);
      // two loads before the boundary, last one wins
      wait_phase(2);
      pulse(16'h1111);
      cyc(3);
      pulse(16'h2222);
      cyc(30);
      // reset while a value is pending and digit 2 is active
      wait_phase(1);
      pulse(16'h5A5A);
      wait_phase(2 * DIV + 1);
      Reset = 1'b1;
      cyc(2);
      Reset = 1'b0;
      cyc(20);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(3));
         v = 16'($urandom);
         case (r)
            1: v = v & 16'h00FF;
            2: v = v & 16'h000F;
            3: v = v & 16'h0FFF;
            default: ;
         endcase
         value = v;
         load  = ($urandom_range(7) == 0);
         if ($urandom_range(31) == 0) blank_en = ~blank_en;
         Reset = ($urandom_range(299) == 0);
         cyc(1);
      end
      load = 1'b0; Reset = 1'b0;
      cyc(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
